// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response channels and the shared memory port of mem_port_arbiter.
// The master modport is the arbiter's view; slave is the core/memory environment.
interface mem_port_arbiter_if #(
   parameter int AW = 32
);
   logic          stall;
   logic          imem_ready;
   logic [AW-1:0] imem_addr;
   logic          imem_valid;
   logic          imem_rresp;
   logic [31:0]   imem_rdata;
   logic          dmem_wready;
   logic [AW-1:0] dmem_waddr;
   logic [31:0]   dmem_wdata;
   logic [3:0]    dmem_wstrb;
   logic          dmem_wvalid;
   logic          dmem_rready;
   logic [AW-1:0] dmem_raddr;
   logic          dmem_rvalid;
   logic          dmem_rresp;
   logic [31:0]   dmem_rdata;
   logic          mem_ready;
   logic          mem_valid;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wstrb;
   logic          mem_rresp;
   logic [31:0]   mem_rdata;
   logic          resp_err;

   modport master (
      input  stall, imem_ready, imem_addr, dmem_wready, dmem_waddr, dmem_wdata,
             dmem_wstrb, dmem_rready, dmem_raddr, mem_valid, mem_rresp, mem_rdata,
      output imem_valid, imem_rresp, imem_rdata, dmem_wvalid, dmem_rvalid,
             dmem_rresp, dmem_rdata, mem_ready, mem_we, mem_addr, mem_wdata,
             mem_wstrb, resp_err
   );

   modport slave (
      output stall, imem_ready, imem_addr, dmem_wready, dmem_waddr, dmem_wdata,
             dmem_wstrb, dmem_rready, dmem_raddr, mem_valid, mem_rresp, mem_rdata,
      input  imem_valid, imem_rresp, imem_rdata, dmem_wvalid, dmem_rvalid,
             dmem_rresp, dmem_rdata, mem_ready, mem_we, mem_addr, mem_wdata,
             mem_wstrb, resp_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between imem read, dmem write and dmem read,
// with an in-order tag FIFO that steers read responses back to their requester.
module mem_port_arbiter #(
   parameter int RESPLEN = 4,
   parameter int AW      = 32
) (
   input logic               clk,
   input logic               resetb,
   mem_port_arbiter_if.master bus
);
   localparam int PW = $clog2(RESPLEN);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(RESPLEN);

   typedef enum logic {ARB, HOLD} state_t;

   state_t        state_reg, state_next;
   logic [1:0]    owner_reg, owner_next;
   logic [1:0]    rr_ptr_reg, rr_ptr_next;
   logic [PW:0]   count_reg;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic          tag_mem [RESPLEN];
   logic          resp_err_reg;

   logic [2:0]    req, elig;
   logic          fifo_full;
   logic [1:0]    cand [3];
   logic [1:0]    winner;
   logic          present;
   logic [1:0]    sel;
   logic          accept, push, pop, head_tag;
   logic [AW-1:0] sel_addr;

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   assign req       = {bus.dmem_rready, bus.dmem_wready, bus.imem_ready};
   assign fifo_full = (count_reg == FULL_COUNT);
   // Reads need a free tag slot; a pop in the same cycle does not free one early.
   assign elig      = {req[2] & ~fifo_full, req[1], req[0] & ~fifo_full};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cand
         logic [2:0] sum;
         assign sum      = {1'b0, rr_ptr_reg} + 3'(gi);
         assign cand[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      end
   endgenerate

   always_comb begin
      winner = cand[0];
      for (int k = 2; k >= 0; k--) begin
         if (elig[cand[k]]) winner = cand[k];
      end
   end

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      present     = 1'b0;
      sel         = winner;
      if (!bus.stall) begin
         if (state_reg == HOLD) begin
            sel = owner_reg;
            if (req[owner_reg]) begin
               present = 1'b1;
               if (bus.mem_valid) begin
                  state_next  = ARB;
                  rr_ptr_next = next_idx(owner_reg);
               end
            end else begin
               state_next = ARB;
            end
         end else if (|elig) begin
            present = 1'b1;
            if (bus.mem_valid) begin
               rr_ptr_next = next_idx(winner);
            end else begin
               state_next = HOLD;
               owner_next = winner;
            end
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      if (present) begin
         unique case (sel)
            2'd0:    sel_addr = bus.imem_addr;
            2'd1:    sel_addr = bus.dmem_waddr;
            default: sel_addr = bus.dmem_raddr;
         endcase
      end
   end

   assign accept   = present & bus.mem_valid;
   assign push     = accept & (sel != 2'd1);
   assign pop      = bus.mem_rresp & (count_reg != '0);
   assign head_tag = tag_mem[rd_ptr_reg];

   assign bus.mem_ready   = present;
   assign bus.mem_we      = present & (sel == 2'd1);
   assign bus.mem_addr    = sel_addr;
   assign bus.mem_wdata   = (present && sel == 2'd1) ? bus.dmem_wdata : 32'd0;
   assign bus.mem_wstrb   = (present && sel == 2'd1) ? bus.dmem_wstrb : 4'd0;
   assign bus.imem_valid  = accept & (sel == 2'd0);
   assign bus.dmem_wvalid = accept & (sel == 2'd1);
   assign bus.dmem_rvalid = accept & (sel == 2'd2);
   assign bus.imem_rresp  = pop & ~head_tag;
   assign bus.dmem_rresp  = pop & head_tag;
   assign bus.imem_rdata  = (pop && !head_tag) ? bus.mem_rdata : 32'd0;
   assign bus.dmem_rdata  = (pop && head_tag) ? bus.mem_rdata : 32'd0;
   assign bus.resp_err    = resp_err_reg;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_reg    <= ARB;
         owner_reg    <= 2'd0;
         rr_ptr_reg   <= 2'd0;
         count_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         resp_err_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         rr_ptr_reg <= rr_ptr_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         unique case ({push, pop})
            2'b10:   count_reg <= count_reg + (PW+1)'(1);
            2'b01:   count_reg <= count_reg - (PW+1)'(1);
            default: ;
         endcase
         if (bus.mem_rresp && count_reg == '0) resp_err_reg <= 1'b1;
      end
   end

   // Tag 1 marks a dmem read, 0 an imem read.
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr_reg] <= (sel == 2'd2);
   end
endmodule
